// File: rtl/rvfpm_pkg.sv
// Shared encodings and pipeline types for the rvfpm FP move paths.
package rvfpm_pkg;

  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] F7_FMV_W_X = 7'b1111000;
  localparam logic [6:0] F7_FMV_X_W = 7'b1110000;
  localparam logic [2:0] F3_FMV     = 3'b000;

  // One in-flight FP register write.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } fmv_stage_t;

endpackage

// File: rtl/rvfpm_fmv_scoreboard.sv
// Per-register pending-write counters for the FMV.W.X path. A register is
// busy while at least one write to it is still travelling down the pipe,
// and an FMV.X.W reading a busy register is stalled at issue.
module rvfpm_fmv_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                inc_valid,   // a write to inc_rd issues this edge
  input  logic [4:0]          inc_rd,
  input  logic                dec_valid,   // a write to dec_rd retires this edge
  input  logic [4:0]          dec_rd,
  input  logic                rd_req,      // enabled FMV.X.W with a legal source
  input  logic [4:0]          rd_idx,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall
);

  localparam int CW = $clog2(PIPELINE_STAGES + 1);

  logic [CW-1:0]       count_q [NUM_REGS];
  logic [CW-1:0]       count_d [NUM_REGS];
  logic [NUM_REGS-1:0] inc_hit;
  logic [NUM_REGS-1:0] dec_hit;

  // Next counter values: issue and retire of the same register cancel out.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d[r] = count_q[r];
      inc_hit[r] = inc_valid && (inc_rd == 5'(r));
      dec_hit[r] = dec_valid && (dec_rd == 5'(r));
      if (inc_hit[r] && !dec_hit[r]) begin
        count_d[r] = count_q[r] + CW'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        count_d[r] = count_q[r] - CW'(1);
      end
    end
  end

  // Counter state; reset clears every pending write.
  always_ff @(posedge ck) begin
    // NOTE: the counter array is small and must start from zero for busy to
    // mean anything, so every entry is reset rather than left undefined.
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) count_q[r] <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Busy flags and the FMV.X.W read-after-write stall.
  always_comb begin
    busy  = '0;
    stall = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy[r] = (count_q[r] != '0);
      if (rd_idx == 5'(r)) stall = rd_req && busy[r];
    end
  end

endmodule

// File: rtl/rvfpm_fmv_w_x_path.sv
// Integer-to-FP move path (FMV.W.X): decodes the offloaded instruction,
// carries rs1 data through PIPELINE_STAGES registers and emits one FP
// register-file write per retired instruction. The last pipeline register
// drives the write port directly.
// Optional macro RVFPM_FMV_CNT_EN adds a saturating retired-write counter.
module rvfpm_fmv_w_x_path
  import rvfpm_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                enable,
  input  logic [31:0]         instruction,
  input  logic [31:0]         data_fromXReg,
  output logic                wr_valid,
  output logic [4:0]          wr_addr,
  output logic [31:0]         wr_data,
  output logic [NUM_REGS-1:0] busy,
  output logic                stall,
  output logic                illegal_rd
`ifdef RVFPM_FMV_CNT_EN
  , output logic [31:0]       fmv_retired_cnt
`endif
);

  localparam int LAST = PIPELINE_STAGES - 1;

  logic       dec_wx;
  logic       dec_xw;
  logic [4:0] dst_rd;
  logic [4:0] src_rs;
  logic       rd_legal;
  logic       rs_legal;
  logic       xw_req;
  logic       issue;
  logic       illegal_issue;
  logic       retire_valid;
  logic [4:0] retire_rd;
  logic       unused_rs1;

  fmv_stage_t stage_q [PIPELINE_STAGES];
  fmv_stage_t stage_d [PIPELINE_STAGES];
  fmv_stage_t feed    [PIPELINE_STAGES];
  logic       illegal_rd_q;
  logic       illegal_rd_d;

  // rs1 carries no meaning for either move; its value arrives on data_fromXReg.
  assign unused_rs1 = ^instruction[19:15];

  // Decode FMV.W.X (issue) and FMV.X.W (stall check only).
  always_comb begin
    dst_rd   = instruction[11:7];
    src_rs   = instruction[24:20];
    dec_wx   = (instruction[6:0] == OPC_OP_FP) && (instruction[31:25] == F7_FMV_W_X) &&
               (instruction[24:20] == 5'd0) && (instruction[14:12] == F3_FMV);
    dec_xw   = (instruction[6:0] == OPC_OP_FP) && (instruction[31:25] == F7_FMV_X_W) &&
               (instruction[14:12] == F3_FMV);
    rd_legal = int'(dst_rd) < NUM_REGS;
    rs_legal = int'(src_rs) < NUM_REGS;
    xw_req   = enable && dec_xw && rs_legal;
    issue         = enable && !stall && dec_wx && rd_legal;
    illegal_issue = enable && !stall && dec_wx && !rd_legal;
  end

  // Shift the pipe on enabled edges; the last entry keeps its address and
  // data when a bubble arrives so the write port holds its last value.
  always_comb begin
    feed[0].valid = issue;
    feed[0].rd    = dst_rd;
    feed[0].data  = data_fromXReg;
    for (int i = 1; i < PIPELINE_STAGES; i++) feed[i] = stage_q[i-1];
    for (int i = 0; i < PIPELINE_STAGES; i++) begin
      stage_d[i] = stage_q[i];
      if (enable) stage_d[i] = feed[i];
    end
    if (enable && !feed[LAST].valid) begin
      stage_d[LAST].valid = 1'b0;
      stage_d[LAST].rd    = stage_q[LAST].rd;
      stage_d[LAST].data  = stage_q[LAST].data;
    end
    retire_valid = enable && feed[LAST].valid;
    retire_rd    = feed[LAST].rd;
    illegal_rd_d = enable ? illegal_issue : illegal_rd_q;
  end

  // Pipeline and illegal-rd registers; reset discards in-flight writes.
  always_ff @(posedge ck) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < PIPELINE_STAGES; i++) stage_q[i] <= '0;
      illegal_rd_q <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      illegal_rd_q <= illegal_rd_d;
    end
  end

  assign wr_valid   = stage_q[LAST].valid;
  assign wr_addr    = stage_q[LAST].rd;
  assign wr_data    = stage_q[LAST].data;
  assign illegal_rd = illegal_rd_q;

  // A write is pending from issue until it moves into the write register.
  rvfpm_fmv_scoreboard #(
    .NUM_REGS        (NUM_REGS),
    .PIPELINE_STAGES (PIPELINE_STAGES)
  ) u_scoreboard (
    .ck        (ck),
    .rst       (rst),
    .inc_valid (issue),
    .inc_rd    (dst_rd),
    .dec_valid (retire_valid),
    .dec_rd    (retire_rd),
    .rd_req    (xw_req),
    .rd_idx    (src_rs),
    .busy      (busy),
    .stall     (stall)
  );

`ifdef RVFPM_FMV_CNT_EN
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Count write-strobe cycles, saturating at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_valid && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  // Retired-write counter register.
  always_ff @(posedge ck) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fmv_retired_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rvfpm_fmv_w_x_path.sv
// Self-checking bench for rvfpm_fmv_w_x_path (NUM_REGS=16, 4 stages).
module tb_rvfpm_fmv_w_x_path;

  localparam int NR = 16;
  localparam int PS = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          ck;
  logic          rst;
  logic          enable;
  logic [31:0]   instruction;
  logic [31:0]   data_fromXReg;
  logic          wr_valid;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic [NR-1:0] busy;
  logic          stall;
  logic          illegal_rd;
`ifdef RVFPM_FMV_CNT_EN
  logic [31:0]   fmv_retired_cnt;
`endif

  int   checks;
  int   errors;
  int   en_cnt;
  logic fresh_q;
  int   wb_cnt;
  exp_t exp_q[$];

  rvfpm_fmv_w_x_path #(.NUM_REGS(NR), .PIPELINE_STAGES(PS)) dut (
    .ck            (ck),
    .rst           (rst),
    .enable        (enable),
    .instruction   (instruction),
    .data_fromXReg (data_fromXReg),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .stall         (stall),
    .illegal_rd    (illegal_rd)
`ifdef RVFPM_FMV_CNT_EN
    , .fmv_retired_cnt (fmv_retired_cnt)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_wx(input logic [4:0] rd);
    return {7'b1111000, 5'd0, 5'd1, 3'b000, rd, 7'b1010011};
  endfunction

  function automatic logic [31:0] enc_xw(input logic [4:0] rs);
    return {7'b1110000, rs, 5'd2, 3'b000, 5'd4, 7'b1010011};
  endfunction

  // Count enabled, non-reset edges; a write is fresh after such an edge.
  always @(posedge ck) begin
    fresh_q <= enable && !rst;
    if (enable && !rst) en_cnt <= en_cnt + 1;
    if (rst) wb_cnt <= 0;
    else if (wr_valid) wb_cnt <= wb_cnt + 1;
  end

  // Writeback monitor: compare each fresh write against the scoreboard.
  always @(negedge ck) begin
    if (fresh_q && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", wr_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_addr", wr_addr, e.rd);
        check("wb_data", wr_data, e.data);
        check("wb_lat", en_cnt, e.due);
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] d, input logic en);
    @(negedge ck);
    instruction   = ins;
    data_fromXReg = d;
    enable        = en;
  endtask

  task automatic issue_wx(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    drive(enc_wx(rd), d, 1'b1);
    if (int'(rd) < NR) begin
      e.rd = rd; e.data = d; e.due = en_cnt + PS;
      exp_q.push_back(e);
    end
  endtask

  task automatic nop();
    drive(32'h0000_0013, $urandom, 1'b1);
  endtask

  initial begin
    checks = 0; errors = 0; en_cnt = 0; wb_cnt = 0; fresh_q = 1'b0;
    rst = 1'b1; enable = 1'b1; instruction = 32'h13; data_fromXReg = '0;

    // 1: reset state
    repeat (2) @(posedge ck);
    @(negedge ck);
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_addr", wr_addr, 5'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", busy, '0);
    check("rst_illegal", illegal_rd, 1'b0);
    rst = 1'b0;

    // 2: single write, latency and busy lifetime
    drive(enc_xw(5'd5), 32'd0, 1'b1);
    #1 check("stall_idle", stall, 1'b0);
    issue_wx(5'd5, 32'h3F80_0000);
    nop();
    check("busy5_set", busy, 16'h0020);
    repeat (4) nop();
    check("busy5_clr", busy, '0);

    // FMV.W.X with rs2 != 0 is not a move: nothing issues
    drive({7'b1111000, 5'd1, 5'd1, 3'b000, 5'd6, 7'b1010011}, 32'hDEAD, 1'b1);
    nop();
    check("bad_rs2_busy", busy, '0);

    // 3: FMV.X.W stalls on a pending write until the writeback cycle
    issue_wx(5'd5, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      drive(enc_xw(5'd5), 32'd0, 1'b1);
      #1 check($sformatf("stall_k%0d", k), stall, (k < 3));
    end
    drive(enc_xw(5'd5), 32'd0, 1'b0);
    #1 check("stall_disabled", stall, 1'b0);
    repeat (2) nop();

    // back-to-back writes to rd=7
    issue_wx(5'd7, 32'hAAAA_0001);
    issue_wx(5'd7, 32'hAAAA_0002);
    for (int k = 0; k < 4; k++) begin
      nop();
      check($sformatf("busy7_k%0d", k), busy[7], (k < 3));
    end
    repeat (2) nop();

    // 4: freeze mid-flight for three cycles
    issue_wx(5'd3, 32'hCAFE_F00D);
    nop();
    for (int k = 0; k < 3; k++) begin
      drive(enc_wx(5'd4), 32'h5555, 1'b0);
      check($sformatf("frz_busy_k%0d", k), busy, 16'h0008);
      check($sformatf("frz_wrv_k%0d", k), wr_valid, 1'b0);
    end
    repeat (5) nop();
    check("frz_busy_clr", busy, '0);

    // 5: illegal rd, and the highest legal rd
    issue_wx(5'd20, 32'h0BAD_0BAD);
    nop();
    check("illegal_pulse", illegal_rd, 1'b1);
    check("illegal_busy", busy, '0);
    nop();
    check("illegal_clr", illegal_rd, 1'b0);
    issue_wx(5'd15, 32'h0F0F_0F0F);
    drive(enc_xw(5'd20), 32'd0, 1'b1);
    #1 check("stall_oob_src", stall, 1'b0);
    check("busy15_set", busy, 16'h8000);
    repeat (5) nop();

    // 6: reset discards an in-flight write
    issue_wx(5'd9, 32'h9999_9999);
    nop();
    @(negedge ck);
    rst = 1'b1;
    exp_q.delete();
    @(negedge ck);
    check("rst_mid_busy", busy, '0);
    @(negedge ck);
    rst = 1'b0;
    repeat (6) begin
      nop();
      check("rst_mid_wrv", wr_valid, 1'b0);
    end

    // a final write after reset, then drain
    issue_wx(5'd1, 32'h0000_0001);
    repeat (PS + 2) nop();
    check("sb_drain", exp_q.size(), 0);
`ifdef RVFPM_FMV_CNT_EN
    check("retired_cnt", fmv_retired_cnt, wb_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
